// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants for the byte-level I2C master.
//   CMD_* : bit positions inside the 4-bit command word.
//   state_t : one-hot FSM encoding used by i2c_master_core.
//   first_state() : decode of an accepted command into its first bus state.
package i2c_pkg;

  localparam int CMD_START = 0;
  localparam int CMD_WRITE = 1;
  localparam int CMD_READ  = 2;
  localparam int CMD_STOP  = 3;

  localparam int SCL_PERIOD_DEF = 500;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_START = 7'b0000010,
    S_WRITE = 7'b0000100,
    S_RACK  = 7'b0001000,
    S_READ  = 7'b0010000,
    S_SACK  = 7'b0100000,
    S_STOP  = 7'b1000000
  } state_t;

  // Priority START > WRITE > READ > STOP; an empty command stays idle.
  function automatic state_t first_state(input logic [3:0] c);
    state_t s;
    s = S_IDLE;
    if      (c[CMD_START]) s = S_START;
    else if (c[CMD_WRITE]) s = S_WRITE;
    else if (c[CMD_READ])  s = S_READ;
    else if (c[CMD_STOP])  s = S_STOP;
    return s;
  endfunction

endpackage

// File: rtl/i2c_master_core_if.sv
// i2c_master_core_if: command handshake plus SDA/SCL pad signals.
//   req/cmd/din/rd_nack    : command from the controller
//   ready/busy/dout/done/ack_err : status back to the controller
//   i2c_scl, i2c_sda_o/oe  : pad drive; i2c_scl_i/i2c_sda_i : sampled pads
// Modport slave is the engine's view; master is the controller/pad view.
interface i2c_master_core_if;
  logic       req;
  logic [3:0] cmd;
  logic [7:0] din;
  logic       rd_nack;
  logic       ready;
  logic       busy;
  logic [7:0] dout;
  logic       done;
  logic       ack_err;
  logic       i2c_scl;
  logic       i2c_scl_i;
  logic       i2c_sda_i;
  logic       i2c_sda_o;
  logic       i2c_sda_oe;

  modport slave (
    input  req, cmd, din, rd_nack, i2c_scl_i, i2c_sda_i,
    output ready, busy, dout, done, ack_err, i2c_scl, i2c_sda_o, i2c_sda_oe
  );

  modport master (
    output req, cmd, din, rd_nack, i2c_scl_i, i2c_sda_i,
    input  ready, busy, dout, done, ack_err, i2c_scl, i2c_sda_o, i2c_sda_oe
  );
endinterface

// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: SCL phase counter and per-state bit counter.
//   run       : engine is in a bus state (counters held at 0 otherwise)
//   multi     : current state is 8 bits long (else 1 bit)
//   scl/scl_i : driven SCL level and sampled SCL line (stretch detect)
//   low_pt/high_pt/scl_rise/bit_end/state_end : single-cycle phase strobes
//   cnt_bit   : bit index within the current state
// Macro I2C_CLK_STRETCH_EN: hold the phase counter at mid-period while a
// slave keeps SCL low after it was released.
module i2c_bit_timer #(
  parameter int SCL_PERIOD = 500,
  parameter int LOW_POINT  = SCL_PERIOD/4,
  parameter int HIGH_POINT = 3*SCL_PERIOD/4
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       multi,
  input  logic       scl,
  input  logic       scl_i,
  output logic [2:0] cnt_bit,
  output logic       low_pt,
  output logic       high_pt,
  output logic       scl_rise,
  output logic       bit_end,
  output logic       state_end
);
  localparam int CW = $clog2(SCL_PERIOD);
  localparam logic [CW-1:0] LAST  = CW'(SCL_PERIOD - 1);
  localparam logic [CW-1:0] MID   = CW'(SCL_PERIOD / 2);
  localparam logic [CW-1:0] RISE  = CW'(SCL_PERIOD / 2 - 1);
  localparam logic [CW-1:0] LOW_C = CW'(LOW_POINT);
  localparam logic [CW-1:0] HI_C  = CW'(HIGH_POINT);

  logic [CW-1:0] cnt_scl;
  logic          hold, adv;

`ifdef I2C_CLK_STRETCH_EN
  // SCL released but still read low at mid-period: slave is stretching.
  assign hold = scl && !scl_i && (cnt_scl == MID);
`else
  logic unused_stretch;
  assign hold = 1'b0;
  assign unused_stretch = scl ^ scl_i ^ (cnt_scl == MID);
`endif

  assign adv       = run && !hold;
  assign low_pt    = adv && (cnt_scl == LOW_C);
  assign high_pt   = adv && (cnt_scl == HI_C);
  assign scl_rise  = adv && (cnt_scl == RISE);
  assign bit_end   = adv && (cnt_scl == LAST);
  assign state_end = bit_end && (multi ? (cnt_bit == 3'd7) : (cnt_bit == 3'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_scl <= '0;
      cnt_bit <= '0;
    end else if (!run) begin
      cnt_scl <= '0;
      cnt_bit <= '0;
    end else if (adv) begin
      if (cnt_scl == LAST) begin
        cnt_scl <= '0;
        cnt_bit <= state_end ? 3'd0 : cnt_bit + 3'd1;
      end else begin
        cnt_scl <= cnt_scl + 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_master_core.sv
// i2c_master_core: one I2C command (START/WRITE/READ/STOP combos) per req.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : i2c_master_core_if.slave (handshake + SDA/SCL pads)
// Optional SCL clock stretching via macro I2C_CLK_STRETCH_EN (in i2c_bit_timer).
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter int SCL_PERIOD = SCL_PERIOD_DEF,
  parameter int LOW_POINT  = SCL_PERIOD/4,
  parameter int HIGH_POINT = 3*SCL_PERIOD/4
)(
  input  logic clk,
  input  logic rst_n,
  i2c_master_core_if.slave bus
);
  state_t     state, state_nx;
  logic       wr_q, rd_q, stop_q, nack_q, ack_q;
  logic [7:0] data_q, dout_q;
  logic       done_q, done_nx, ack_err_q, scl_q, sda_q, oe_q;
  logic [2:0] cnt_bit;
  logic       low_pt, high_pt, scl_rise, bit_end, state_end;
  logic       ready, accept;

  // done occupies the first idle cycle, so ready follows one cycle later.
  assign ready  = (state == S_IDLE) && !done_q;
  assign accept = bus.req && ready;

  i2c_bit_timer #(
    .SCL_PERIOD(SCL_PERIOD), .LOW_POINT(LOW_POINT), .HIGH_POINT(HIGH_POINT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state != S_IDLE),
    .multi    ((state == S_WRITE) || (state == S_READ)),
    .scl      (scl_q),
    .scl_i    (bus.i2c_scl_i),
    .cnt_bit  (cnt_bit),
    .low_pt   (low_pt),
    .high_pt  (high_pt),
    .scl_rise (scl_rise),
    .bit_end  (bit_end),
    .state_end(state_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = first_state(bus.cmd);
      S_START: if (state_end) state_nx = wr_q ? S_WRITE : (rd_q ? S_READ : S_IDLE);
      S_WRITE: if (state_end) state_nx = S_RACK;
      // A slave NACK always closes the transfer with STOP.
      S_RACK:  if (state_end) state_nx = (stop_q || ack_q) ? S_STOP : S_IDLE;
      S_READ:  if (state_end) state_nx = S_SACK;
      S_SACK:  if (state_end) state_nx = stop_q ? S_STOP : S_IDLE;
      S_STOP:  if (state_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    done_nx = ((state != S_IDLE) && (state_nx == S_IDLE)) ||
              (accept && (bus.cmd == 4'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b0; rd_q <= 1'b0; stop_q <= 1'b0; nack_q <= 1'b0; ack_q <= 1'b0;
      data_q <= '0; dout_q <= '0;
      done_q <= 1'b0; ack_err_q <= 1'b0;
      scl_q <= 1'b1; sda_q <= 1'b1; oe_q <= 1'b0;
    end else begin
      done_q <= done_nx;
      if (accept) begin
        wr_q      <= bus.cmd[CMD_WRITE];
        rd_q      <= bus.cmd[CMD_READ] && !bus.cmd[CMD_WRITE];
        stop_q    <= bus.cmd[CMD_STOP];
        data_q    <= bus.din;
        nack_q    <= bus.rd_nack;
        ack_err_q <= 1'b0;
        if (bus.cmd != 4'd0) scl_q <= 1'b0;
      end
      if (scl_rise) scl_q <= 1'b1;
      // STOP is a single bit, so its wrap is the final one: SCL stays high.
      if (bit_end && (state != S_STOP)) scl_q <= 1'b0;

      if (state_nx != state) begin
        case (state_nx)
          S_START, S_WRITE, S_SACK, S_STOP: oe_q <= 1'b1;
          S_READ, S_RACK:                   oe_q <= 1'b0;
          S_IDLE:  if (state == S_STOP)     oe_q <= 1'b0;
          default: ;
        endcase
      end

      if (low_pt) begin
        case (state)
          S_START: sda_q <= 1'b1;
          S_STOP:  sda_q <= 1'b0;
          S_WRITE: sda_q <= data_q[3'd7 - cnt_bit];
          S_SACK:  sda_q <= nack_q;
          default: ;
        endcase
      end

      if (high_pt) begin
        case (state)
          S_START: sda_q <= 1'b0;
          S_STOP:  sda_q <= 1'b1;
          S_READ:  dout_q[3'd7 - cnt_bit] <= bus.i2c_sda_i;
          S_RACK: begin
            ack_q <= bus.i2c_sda_i;
            if (bus.i2c_sda_i) ack_err_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ready      = ready;
  assign bus.busy       = !ready;
  assign bus.dout       = dout_q;
  assign bus.done       = done_q;
  assign bus.ack_err    = ack_err_q;
  assign bus.i2c_scl    = scl_q;
  assign bus.i2c_sda_o  = sda_q;
  assign bus.i2c_sda_oe = oe_q;
endmodule

// File: tb/tb_i2c_master_core.sv
// tb_i2c_master_core: directed bench for i2c_master_core at SCL_PERIOD=16.
// A behavioural slave drives SDA per SCL period from a bit vector
// (bit k = level released/driven during period k). Latency counts clk
// cycles from the accept edge to the edge that raises done.
module tb_i2c_master_core;
  localparam int P = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_master_core_if bus();

  i2c_master_core #(.SCL_PERIOD(P)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic slave_sda = 1'b1;
  logic stretch_lo = 1'b0;
  assign bus.i2c_sda_i = (bus.i2c_sda_oe ? bus.i2c_sda_o : 1'b1) & slave_sda;
  assign bus.i2c_scl_i = bus.i2c_scl & ~stretch_lo;

  int checks = 0;
  int failures = 0;

  logic [15:0] rises, oe_rise;
  logic start_seen, stop_seen;
  logic ab_scl, ab_oe, ab_ready, ab_done;

  function automatic logic bus_sda();
    return (bus.i2c_sda_oe ? bus.i2c_sda_o : 1'b1) & slave_sda;
  endfunction

  function automatic logic [7:0] byte_at(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = rises[base+i];
    return r;
  endfunction

  // Issue one command and follow it to done (lat=-1 if it never comes).
  task automatic run_cmd(input logic [3:0] c, input logic [7:0] d, input logic nk,
                         input logic [15:0] sb, input int busy_at, input int rst_at,
                         input int str_p, output int lat, output int wrdy);
    int cyc, p, scnt;
    logic pscl, psda, line;
    lat = -1; wrdy = 0; scnt = 0;
    rises = '1; oe_rise = '0; start_seen = 1'b0; stop_seen = 1'b0;
    @(negedge clk);
    while (!bus.ready && wrdy < 100) begin @(negedge clk); wrdy++; end
    if (!bus.ready) return;
    bus.req = 1'b1; bus.cmd = c; bus.din = d; bus.rd_nack = nk;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    cyc = 0; p = 0; slave_sda = sb[0];
    pscl = bus.i2c_scl; psda = bus_sda();
    while (cyc < 2000) begin
      if (cyc == rst_at) begin
        #2 rst_n = 1'b0;
        #1 begin ab_scl = bus.i2c_scl; ab_oe = bus.i2c_sda_oe; ab_ready = bus.ready; ab_done = bus.done; end
        slave_sda = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      if (cyc == busy_at) begin bus.req = 1'b1; bus.cmd = 4'b0100; bus.din = 8'hFF; end
      if (cyc == busy_at + 5) bus.req = 1'b0;
      if (stretch_lo) begin scnt--; if (scnt == 0) stretch_lo = 1'b0; end
      if (cyc != 0 && pscl && !bus.i2c_scl) begin
        p++;
        if (p < 16) slave_sda = sb[p];
      end
      line = bus_sda();
      if (!pscl && bus.i2c_scl && p < 16) begin
        rises[p] = line; oe_rise[p] = bus.i2c_sda_oe;
        if (p == str_p) begin stretch_lo = 1'b1; scnt = 40; end
      end
      if (cyc != 0 && pscl && bus.i2c_scl) begin
        if (psda && !line) start_seen = 1'b1;
        if (!psda && line) stop_seen = 1'b1;
      end
      if (bus.done) begin lat = cyc; break; end
      pscl = bus.i2c_scl; psda = line;
      @(negedge clk); cyc++;
    end
    slave_sda = 1'b1; stretch_lo = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 1'b0; bus.cmd = 4'd0; bus.din = 8'd0; bus.rd_nack = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    checks++; if (bus.ack_err !== 1'b0) begin failures++; $display("FAIL rst_ack_err got=%b exp=0", bus.ack_err); end
    checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h exp=00", bus.dout); end
    checks++; if (bus.i2c_scl !== 1'b1) begin failures++; $display("FAIL rst_scl got=%b exp=1", bus.i2c_scl); end
    checks++; if (bus.i2c_sda_o !== 1'b1) begin failures++; $display("FAIL rst_sda_o got=%b exp=1", bus.i2c_sda_o); end
    checks++; if (bus.i2c_sda_oe !== 1'b0) begin failures++; $display("FAIL rst_sda_oe got=%b exp=0", bus.i2c_sda_oe); end
    rst_n = 1'b1;
  endtask

  task automatic test_start_write();
    int lat, w;
    run_cmd(4'b0011, 8'hA5, 1'b0, 16'hFDFF, -1, -1, -1, lat, w);
    checks++; if (lat !== 160) begin failures++; $display("FAIL sw_latency got=%0d exp=160", lat); end
    checks++; if (byte_at(1) !== 8'hA5) begin failures++; $display("FAIL sw_byte got=%h exp=a5", byte_at(1)); end
    checks++; if (start_seen !== 1'b1) begin failures++; $display("FAIL sw_start_cond got=%b exp=1", start_seen); end
    checks++; if (oe_rise[9] !== 1'b0) begin failures++; $display("FAIL sw_oe_rack got=%b exp=0", oe_rise[9]); end
    checks++; if (bus.ack_err !== 1'b0) begin failures++; $display("FAIL sw_ack_err got=%b exp=0", bus.ack_err); end
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL sw_ready_at_done got=%b exp=0", bus.ready); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL sw_done_width got=%b exp=0", bus.done); end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL sw_ready_after got=%b exp=1", bus.ready); end
  endtask

  task automatic test_read_stop();
    int lat, w;
    run_cmd(4'b1100, 8'h00, 1'b1, 16'hFF3C, -1, -1, -1, lat, w);
    checks++; if (lat !== 160) begin failures++; $display("FAIL rd_latency got=%0d exp=160", lat); end
    checks++; if (bus.dout !== 8'h3C) begin failures++; $display("FAIL rd_dout got=%h exp=3c", bus.dout); end
    checks++; if (rises[8] !== 1'b1 || oe_rise[8] !== 1'b1) begin failures++; $display("FAIL rd_sack got=%b/%b exp=1/1", rises[8], oe_rise[8]); end
    checks++; if (stop_seen !== 1'b1) begin failures++; $display("FAIL rd_stop_cond got=%b exp=1", stop_seen); end
    checks++; if (bus.i2c_scl !== 1'b1) begin failures++; $display("FAIL rd_scl_end got=%b exp=1", bus.i2c_scl); end
  endtask

  task automatic test_write_nack();
    int lat, w;
    run_cmd(4'b0010, 8'h96, 1'b0, 16'hFFFF, -1, -1, -1, lat, w);
    checks++; if (lat !== 160) begin failures++; $display("FAIL nk_latency got=%0d exp=160", lat); end
    checks++; if (bus.ack_err !== 1'b1) begin failures++; $display("FAIL nk_ack_err got=%b exp=1", bus.ack_err); end
    checks++; if (stop_seen !== 1'b1 || rises[9] !== 1'b0) begin failures++; $display("FAIL nk_forced_stop got=%b/%b exp=1/0", stop_seen, rises[9]); end
    checks++; if (byte_at(0) !== 8'h96) begin failures++; $display("FAIL nk_byte got=%h exp=96", byte_at(0)); end
    repeat (3) @(negedge clk);
    checks++; if (bus.ack_err !== 1'b1) begin failures++; $display("FAIL nk_sticky got=%b exp=1", bus.ack_err); end
    // Empty command: done on the cycle after accept, no bus activity.
    run_cmd(4'b0000, 8'h00, 1'b0, 16'hFFFF, -1, -1, -1, lat, w);
    checks++; if (lat !== 0) begin failures++; $display("FAIL nop_latency got=%0d exp=0", lat); end
    checks++; if (bus.ack_err !== 1'b0) begin failures++; $display("FAIL nop_clear_ack_err got=%b exp=0", bus.ack_err); end
    checks++; if (bus.i2c_scl !== 1'b1) begin failures++; $display("FAIL nop_scl got=%b exp=1", bus.i2c_scl); end
  endtask

  task automatic test_back_to_back();
    int lat, w;
    run_cmd(4'b1011, 8'h5A, 1'b0, 16'hFDFF, 20, -1, -1, lat, w);
    checks++; if (lat !== 176) begin failures++; $display("FAIL busy_latency got=%0d exp=176", lat); end
    checks++; if (byte_at(1) !== 8'h5A) begin failures++; $display("FAIL busy_byte got=%h exp=5a", byte_at(1)); end
    run_cmd(4'b1010, 8'h81, 1'b0, 16'hFEFF, -1, -1, -1, lat, w);
    checks++; if (w !== 0) begin failures++; $display("FAIL b2b_wait got=%0d exp=0", w); end
    checks++; if (lat !== 160) begin failures++; $display("FAIL b2b_latency got=%0d exp=160", lat); end
    checks++; if (byte_at(0) !== 8'h81) begin failures++; $display("FAIL b2b_byte got=%h exp=81", byte_at(0)); end
  endtask

  task automatic test_stretch();
    int lat, w, exp_lat;
`ifdef I2C_CLK_STRETCH_EN
    exp_lat = 200;
`else
    exp_lat = 160;
`endif
    run_cmd(4'b1010, 8'hC3, 1'b0, 16'hFEFF, -1, -1, 3, lat, w);
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL str_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (byte_at(0) !== 8'hC3) begin failures++; $display("FAIL str_byte got=%h exp=c3", byte_at(0)); end
    checks++; if (bus.ack_err !== 1'b0) begin failures++; $display("FAIL str_ack_err got=%b exp=0", bus.ack_err); end
  endtask

  task automatic test_reset_mid();
    int lat, w;
    run_cmd(4'b1011, 8'hFF, 1'b0, 16'hFFFF, -1, 50, -1, lat, w);
    checks++; if (ab_scl !== 1'b1) begin failures++; $display("FAIL mid_scl got=%b exp=1", ab_scl); end
    checks++; if (ab_oe !== 1'b0) begin failures++; $display("FAIL mid_sda_oe got=%b exp=0", ab_oe); end
    checks++; if (ab_ready !== 1'b1 || ab_done !== 1'b0) begin failures++; $display("FAIL mid_ready_done got=%b/%b exp=1/0", ab_ready, ab_done); end
    run_cmd(4'b1010, 8'h3C, 1'b0, 16'hFEFF, -1, -1, -1, lat, w);
    checks++; if (lat !== 160) begin failures++; $display("FAIL mid_next_latency got=%0d exp=160", lat); end
    checks++; if (byte_at(0) !== 8'h3C) begin failures++; $display("FAIL mid_next_byte got=%h exp=3c", byte_at(0)); end
    checks++; if (stop_seen !== 1'b1) begin failures++; $display("FAIL mid_next_stop got=%b exp=1", stop_seen); end
  endtask

  initial begin
    test_reset();
    test_start_write();
    test_read_stop();
    test_write_nack();
    test_back_to_back();
    test_stretch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_master_core.md
Name: i2c_master_core

Overview:
Parametrised byte-level I2C master engine. It is the successor to the current fixed-timing byte master.
- Executes one command per request: START, WRITE byte, READ byte, STOP, or legal combinations.
- Sits between the EEPROM controller FSM and the SDA/SCL pads.
- New over the previous generation: generic SCL timing, per-read ACK/NACK control, sticky ack_err flag, ready/busy handshake, optional SCL clock stretching.

Parameters:
SCL_PERIOD, 500, clk cycles per SCL bit period; must be even and >= 8.
LOW_POINT, SCL_PERIOD/4, cnt_scl value at which SDA changes; SCL is low here.
HIGH_POINT, 3*SCL_PERIOD/4, cnt_scl value at which SDA is sampled; SCL is high here.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  1  command strobe; accepted only while ready=1
cmd  in  4  command flags: [0]START [1]WRITE [2]READ [3]STOP
din  in  8  byte to transmit, captured on accept
rd_nack  in  1  captured on accept; 1 = master sends NACK after a READ
ready  out  1  engine idle, can accept req
busy  out  1  inverse of ready
dout  out  8  last received byte, MSB first
done  out  1  one-cycle pulse when a command completes
ack_err  out  1  slave NACKed a WRITE; sticky until next accepted req
i2c_scl  out  1  SCL level; 1 = released
i2c_scl_i  in  1  sampled SCL line (stretch detect)
i2c_sda_i  in  1  sampled SDA line
i2c_sda_o  out  1  SDA drive value
i2c_sda_oe  out  1  SDA output enable

Behaviour:
- Reset values: ready=1, busy=0, done=0, ack_err=0, dout=0, i2c_scl=1, i2c_sda_o=1, i2c_sda_oe=0, state IDLE, counters 0.
- Asynchronous reset mid-transaction releases both lines immediately. No STOP is generated.
- Accept: req && ready. On accept, capture cmd, din and rd_nack; clear ack_err. A req while busy is ignored, with no capture.
- Decode priority: START, then WRITE, then READ, then STOP.
  - WRITE and READ both set: READ is ignored.
  - cmd=0: done is pulsed on the next cycle, no bus activity.
- States: IDLE, START, WRITE, RACK, READ, SACK, STOP. Transitions:
  - IDLE -> START / WRITE / READ / STOP on accept, per decode.
  - START -> WRITE or READ if flagged; otherwise -> IDLE with done.
  - WRITE (8 bits) -> RACK (1 bit).
  - RACK -> STOP if STOP is flagged or the ACK bit sampled 1; otherwise -> IDLE with done.
  - READ (8 bits) -> SACK (1 bit).
  - SACK -> STOP if STOP is flagged; otherwise -> IDLE with done.
  - STOP -> IDLE with done.
- Bit timing:
  - cnt_scl runs 0..SCL_PERIOD-1 in every non-IDLE state; cnt_bit counts bits per state (8 or 1).
  - i2c_scl goes low on accept and at every wrap of cnt_scl, except the final wrap of STOP.
  - i2c_scl goes high at cnt_scl = SCL_PERIOD/2 - 1.
- START: SDA=1 at LOW_POINT, SDA=0 at HIGH_POINT. STOP: SDA=0 at LOW_POINT, SDA=1 at HIGH_POINT.
- WRITE: SDA = data[7-cnt_bit] at LOW_POINT.
- SACK: SDA = rd_nack at LOW_POINT.
- READ samples SDA into dout[7-cnt_bit] at HIGH_POINT. RACK samples SDA into the ack bit at HIGH_POINT; if the bit is 1, ack_err=1.
- sda_oe:
  - Set on entry to START, WRITE, SACK, STOP.
  - Cleared on entry to READ and RACK.
  - Cleared on STOP -> IDLE.
- NACK on WRITE always forces STOP before done.
- done is asserted in the same cycle the state returns to IDLE. ready rises on the following cycle, and a req in that cycle is accepted.
- Latency in clk cycles from accept to done:
  - START+WRITE: 10*SCL_PERIOD.
  - WRITE+STOP: 10*SCL_PERIOD.
  - READ: 9*SCL_PERIOD.
  - These figures assume no stretching.

Optional Feature:
Macro I2C_CLK_STRETCH_EN.
- Defined: while i2c_scl=1 and i2c_i2c_scl_i reads 0 at cnt_scl = SCL_PERIOD/2, cnt_scl holds its value until i2c_scl_i reads 1. This covers slave clock stretching; all later phase points are delayed by the same amount.
- Undefined: i2c_scl_i is ignored and timing is free-running as above.

Decomposition:
- Package i2c_pkg holds:
  - CMD_START/WRITE/READ/STOP bit constants.
  - One-hot state encodings.
  - Default SCL_PERIOD.
- Sub-module i2c_bit_timer contains:
  - cnt_scl and cnt_bit.
  - Phase strobes: low_pt, high_pt, scl_rise, bit_end, state_end.
  - The stretch hold logic.
- The FSM and datapath remain in i2c_master_core.

Test Plan:
- SCL_PERIOD=16, cmd=START|WRITE, din=0xA5, slave ACKs -> SDA bits at SCL high read 1,0,1,0,0,1,0,1; done pulses 160 cycles after accept; ack_err=0; sda_oe=0 during RACK.
- cmd=READ|STOP, rd_nack=1, slave drives 0x3C -> dout=0x3C; SDA=1 in SACK; STOP condition seen; done after 10 bit periods; i2c_scl ends high.
- cmd=WRITE (no STOP), slave NACKs -> ack_err=1; forced STOP (SDA rises while SCL high); done pulses; next accepted req clears ack_err.
- req asserted with a different cmd/din while busy -> ignored; transmitted byte unchanged; back-to-back req in the cycle after ready rises is accepted.
- With I2C_CLK_STRETCH_EN, slave holds i2c_scl_i low for 40 cycles on bit 3 -> that bit period extends by exactly 40 cycles; data is intact. Without the macro, there is no extension.
- rst_n pulsed low mid-WRITE -> i2c_scl=1 and sda_oe=0 asynchronously; ready=1, done=0; the next command runs normally.
